// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-port arbiter sharing one ALU through an IDLE/EXEC/RESP sequencer.
// Define ALU_ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise port 0 always wins ties.
module alu_arbiter #(
  parameter int MULDIV_CYCLES = 4,
  parameter int WIDTH         = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req0_valid,
  input  logic             req1_valid,
  output logic             req0_ready,
  output logic             req1_ready,
  input  logic [3:0]       req0_operation,
  input  logic [3:0]       req1_operation,
  input  logic [WIDTH-1:0] req0_operand1,
  input  logic [WIDTH-1:0] req0_operand2,
  input  logic [WIDTH-1:0] req1_operand1,
  input  logic [WIDTH-1:0] req1_operand2,
  output logic [3:0]       alu_operation,
  output logic [WIDTH-1:0] alu_operand1,
  output logic [WIDTH-1:0] alu_operand2,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zeroFlag,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zeroFlag,
  output logic             rsp_error
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [3:0] MD_LEN = 4'(MULDIV_CYCLES);

  state_t           state;
  state_t           state_nxt;
  logic [3:0]       cnt;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] opa_q;
  logic [WIDTH-1:0] opb_q;
  logic             id_q;
  logic             grant1;
  logic             accept;
  logic             last_exec;
  logic [3:0]       sel_op;
  logic             sel_muldiv;
  logic             op_undef;

`ifdef ALU_ARB_ROUND_ROBIN_EN
  logic last_grant;

  // On a tie, port 1 wins only if port 0 was granted last.
  assign grant1 = req1_valid & (~req0_valid | ~last_grant);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= 1'b1;
    end else if (accept) begin
      last_grant <= grant1;
    end
  end
`else
  assign grant1 = req1_valid & ~req0_valid;
`endif

  assign accept     = (state == IDLE) && reset_n && (req0_valid || req1_valid);
  assign req0_ready = accept && !grant1;
  assign req1_ready = accept && grant1;

  assign sel_op     = grant1 ? req1_operation : req0_operation;
  assign sel_muldiv = (sel_op == 4'b0010) || (sel_op == 4'b0011);
  assign op_undef   = (op_q > 4'b0101);
  assign last_exec  = (state == EXEC) && (cnt == 4'd1);

  assign alu_operation = op_q;
  assign alu_operand1  = opa_q;
  assign alu_operand2  = opb_q;
  assign rsp_valid     = (state == RESP);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    if (cnt == 4'd1) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      op_q         <= 4'd0;
      opa_q        <= '0;
      opb_q        <= '0;
      id_q         <= 1'b0;
      rsp_id       <= 1'b0;
      rsp_result   <= '0;
      rsp_zeroFlag <= 1'b0;
      rsp_error    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_q  <= sel_op;
        opa_q <= grant1 ? req1_operand1 : req0_operand1;
        opb_q <= grant1 ? req1_operand2 : req0_operand2;
        id_q  <= grant1;
        cnt   <= sel_muldiv ? MD_LEN : 4'd1;
      end else if (state == EXEC && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      // Response fields only change here, so they hold between operations.
      if (last_exec) begin
        rsp_id <= id_q;
        if (op_undef) begin
          rsp_result   <= '0;
          rsp_zeroFlag <= 1'b1;
          rsp_error    <= 1'b1;
        end else begin
          rsp_result   <= alu_result;
          rsp_zeroFlag <= alu_zeroFlag;
          rsp_error    <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter: vector table, scoreboard and corner sequences.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [3:0]  req0_operation, req1_operation;
  logic [63:0] req0_operand1, req0_operand2, req1_operand1, req1_operand2;
  logic [3:0]  alu_operation;
  logic [63:0] alu_operand1, alu_operand2;
  logic [63:0] alu_result;
  logic        alu_zeroFlag;
  logic        rsp_valid, rsp_id, rsp_zeroFlag, rsp_error;
  logic [63:0] rsp_result;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit          id;
    logic [63:0] res;
    bit          zf;
    bit          err;
  } rsp_t;

  typedef struct {
    bit          port;
    logic [3:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] res;
    bit          zf;
    bit          err;
    int          lat;
  } vec_t;

  rsp_t sb[$];
  vec_t vecs[9];

  alu_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_operation(req0_operation), .req1_operation(req1_operation),
    .req0_operand1(req0_operand1), .req0_operand2(req0_operand2),
    .req1_operand1(req1_operand1), .req1_operand2(req1_operand2),
    .alu_operation(alu_operation), .alu_operand1(alu_operand1), .alu_operand2(alu_operand2),
    .alu_result(alu_result), .alu_zeroFlag(alu_zeroFlag),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_zeroFlag(rsp_zeroFlag), .rsp_error(rsp_error)
  );

  always #5 clk = ~clk;

  // Behaviour of the shared ALU; undefined opcodes return junk the DUT must discard.
  function automatic logic [63:0] alu_fn(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a * b;
      4'd3:    return (b == 0) ? '1 : a / b;
      4'd4:    return a << b[5:0];
      4'd5:    return a >> b[5:0];
      default: return 64'hDEAD_BEEF;
    endcase
  endfunction

  function automatic rsp_t expect_rsp(input bit id, input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    rsp_t r;
    r.id = id;
    if (op > 4'd5) begin
      r.res = '0; r.zf = 1'b1; r.err = 1'b1;
    end else begin
      r.res = alu_fn(op, a, b); r.zf = (r.res == 0); r.err = 1'b0;
    end
    return r;
  endfunction

  assign alu_result   = alu_fn(alu_operation, alu_operand1, alu_operand2);
  assign alu_zeroFlag = (alu_result == 64'd0);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: push on every grant, pop and compare on every response.
  always @(negedge clk) begin
    if (!reset_n) begin
      sb.delete();
    end else begin
      if (req0_ready) sb.push_back(expect_rsp(1'b0, req0_operation, req0_operand1, req0_operand2));
      if (req1_ready) sb.push_back(expect_rsp(1'b1, req1_operation, req1_operand1, req1_operand2));
      if (rsp_valid) begin
        check("sb_nonempty", (sb.size() != 0), 1);
        if (sb.size() != 0) begin
          rsp_t e;
          e = sb.pop_front();
          check("sb_rsp_id", rsp_id, e.id);
          check("sb_rsp_result", rsp_result, e.res);
          check("sb_rsp_zeroFlag", rsp_zeroFlag, e.zf);
          check("sb_rsp_error", rsp_error, e.err);
        end
      end
    end
  end

  task automatic drive_port(input bit port, input bit v, input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    if (port) begin
      req1_valid = v; req1_operation = op; req1_operand1 = a; req1_operand2 = b;
    end else begin
      req0_valid = v; req0_operation = op; req0_operand1 = a; req0_operand2 = b;
    end
  endtask

  task automatic run_vec(input vec_t v);
    bit seen;
    logic [63:0] held;
    @(posedge clk); #1;
    drive_port(v.port, 1'b1, v.op, v.a, v.b);
    @(negedge clk);
    check("ready_granted", v.port ? req1_ready : req0_ready, 1);
    check("ready_other", v.port ? req0_ready : req1_ready, 0);
    @(posedge clk); #1;
    drive_port(v.port, 1'b0, 4'd0, 64'd0, 64'd0);
    seen = 1'b0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        seen = 1'b1;
        check("latency", i, v.lat);
        check("rsp_result", rsp_result, v.res);
        check("rsp_zeroFlag", rsp_zeroFlag, v.zf);
        check("rsp_error", rsp_error, v.err);
        check("rsp_id", rsp_id, v.port);
      end else begin
        check("alu_operation_stable", alu_operation, v.op);
        check("alu_operand1_stable", alu_operand1, v.a);
        check("alu_operand2_stable", alu_operand2, v.b);
      end
    end
    check("rsp_seen", seen, 1);
    held = rsp_result;
    @(negedge clk);
    check("rsp_valid_one_cycle", rsp_valid, 0);
    check("rsp_result_hold", rsp_result, held);
  endtask

  initial begin
    int gexp[4];
    int ng, prev;
    bit found;

    vecs[0] = '{1'b0, 4'd0, 64'hFFFF, 64'h2,  64'h10001, 1'b0, 1'b0, 2};
    vecs[1] = '{1'b1, 4'd2, 64'hF,    64'h10, 64'hF0,    1'b0, 1'b0, 5};
    vecs[2] = '{1'b0, 4'd9, 64'h1234, 64'h1,  64'h0,     1'b1, 1'b1, 2};
    vecs[3] = '{1'b0, 4'd1, 64'h5,    64'h5,  64'h0,     1'b1, 1'b0, 2};
    vecs[4] = '{1'b1, 4'd3, 64'h100,  64'h7,  64'h24,    1'b0, 1'b0, 5};
    vecs[5] = '{1'b0, 4'd4, 64'h1,    64'd63, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 2};
    vecs[6] = '{1'b1, 4'd5, 64'h80,   64'd4,  64'h8,     1'b0, 1'b0, 2};
    vecs[7] = '{1'b1, 4'hF, 64'h0,    64'h0,  64'h0,     1'b1, 1'b1, 2};
    vecs[8] = '{1'b0, 4'd1, 64'h0,    64'h1,  64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 2};
`ifdef ALU_ARB_ROUND_ROBIN_EN
    gexp = '{0, 1, 0, 1};
`else
    gexp = '{0, 0, 0, 0};
`endif

    reset_n = 1'b0;
    drive_port(1'b0, 1'b1, 4'd0, 64'd1, 64'd1);
    drive_port(1'b1, 1'b0, 4'd0, 64'd0, 64'd0);
    #12;
    check("reset_req0_ready", req0_ready, 0);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_rsp_result", rsp_result, 0);
    check("reset_rsp_flags", {rsp_id, rsp_zeroFlag, rsp_error}, 0);
    check("reset_alu_operation", alu_operation, 0);
    check("reset_alu_operands", alu_operand1 | alu_operand2, 0);
    drive_port(1'b0, 1'b0, 4'd0, 64'd0, 64'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // Reset in the second EXEC cycle of a div aborts it with no response.
    @(posedge clk); #1;
    drive_port(1'b0, 1'b1, 4'd3, 64'd100, 64'd5);
    @(negedge clk);
    check("div_ready", req0_ready, 1);
    @(posedge clk); #1;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("abort_rsp_valid", rsp_valid, 0);
    check("abort_rsp_result", rsp_result, 0);
    check("abort_rsp_flags", {rsp_id, rsp_zeroFlag, rsp_error}, 0);
    check("abort_alu_operation", alu_operation, 0);
    check("abort_alu_operands", alu_operand1 | alu_operand2, 0);
    check("abort_req0_ready", req0_ready, 0);
    drive_port(1'b0, 1'b0, 4'd0, 64'd0, 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_no_rsp", rsp_valid, 0);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Both requesters held valid with sub operations.
    @(posedge clk); #1;
    drive_port(1'b0, 1'b1, 4'd1, 64'h9, 64'h4);
    drive_port(1'b1, 1'b1, 4'd1, 64'h20, 64'h1);
    ng = 0; prev = 0;
    for (int i = 0; i < 40 && ng < 4; i++) begin
      @(negedge clk);
      if (req0_ready || req1_ready) begin
        check("ready_onehot", req0_ready & req1_ready, 0);
        check("grant_seq", req1_ready, gexp[ng]);
        if (ng > 0) check("grant_spacing", i - prev, 3);
        prev = i;
        ng++;
      end
    end
    check("grant_count", ng, 4);
    @(posedge clk); #1;
    drive_port(1'b0, 1'b0, 4'd0, 64'd0, 64'd0);
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      @(negedge clk);
      if (req1_ready) found = 1'b1;
    end
    check("stalled_req1_granted", found, 1);
    @(posedge clk); #1;
    drive_port(1'b1, 1'b0, 4'd0, 64'd0, 64'd0);
    repeat (6) @(negedge clk);

    run_vec('{1'b0, 4'd0, 64'h30, 64'h12, 64'h42, 1'b0, 1'b0, 2});

    repeat (2) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter MULDIV_CYCLES, default 4, number of EXEC cycles for mul (0010) and div (0011); legal range 1-15.
REQ-002 SHALL have parameter WIDTH, default 64, operand/result width.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports req0_valid/req1_valid  input  1  each  requester has an operation pending.
REQ-006 SHALL have ports req0_ready/req1_ready  output  1  each  request accepted this cycle.
REQ-007 SHALL have ports req0_operation/req1_operation  input  4  ALU opcode: 0000 add, 0001 sub, 0010 mul, 0011 div, 0100 shl, 0101 shr.
REQ-008 SHALL have ports req0_operand1/req0_operand2/req1_operand1/req1_operand2  input  WIDTH  operands.
REQ-009 SHALL have ports alu_operation  output  4, alu_operand1/alu_operand2  output  WIDTH  drive the shared ALU.
REQ-010 SHALL have ports alu_result  input  WIDTH, alu_zeroFlag  input  1  returned by the shared ALU.
REQ-011 SHALL have ports rsp_valid  output  1, rsp_id  output  1 (requester index), rsp_result  output  WIDTH, rsp_zeroFlag  output  1, rsp_error  output  1 (undefined opcode).

Function
REQ-012 SHALL implement FSM states IDLE, EXEC, RESP; reset state IDLE.
REQ-013 In IDLE with any reqN_valid, SHALL assert exactly one reqN_ready combinationally for the granted port, latch its opcode/operands/index, and enter EXEC at that edge.
REQ-014 reqN_ready SHALL be 0 in EXEC and RESP; requests then stall with no loss.
REQ-015 alu_operation/alu_operand1/alu_operand2 SHALL come from latched registers and stay stable for all of EXEC.
REQ-016 EXEC length SHALL be MULDIV_CYCLES cycles for 0010/0011 and 1 cycle for all other opcodes; a 4-bit down-counter tracks it.
REQ-017 On the last EXEC cycle SHALL capture alu_result and alu_zeroFlag into rsp_result/rsp_zeroFlag, and enter RESP.
REQ-018 In RESP, rsp_valid SHALL be 1 for exactly one cycle with rsp_id set; no back-pressure; next state IDLE.
REQ-019 Opcodes 0110-1111 SHALL take 1 EXEC cycle and respond with rsp_result=0, rsp_zeroFlag=1, rsp_error=1; rsp_error SHALL be 0 otherwise.
REQ-020 Latency: accept edge to rsp_valid high = EXEC length + 1 cycles; throughput one operation per EXEC length + 2 cycles.
REQ-021 rsp_result/rsp_zeroFlag/rsp_id SHALL hold their last values until the next capture.
REQ-022 Single valid requester SHALL always be granted regardless of arbitration history.

Reset
REQ-023 reset_n low SHALL immediately force IDLE, counter 0, all latched operands/opcode 0, reqN_ready 0, rsp_valid 0, rsp_id 0, rsp_result 0, rsp_zeroFlag 0, rsp_error 0, last-grant register 1.
REQ-024 Reset during EXEC or RESP SHALL abort the operation with no rsp_valid pulse; first grant after release follows REQ-023 state.

Configuration
REQ-025 With ALU_ARB_ROUND_ROBIN_EN defined, simultaneous valid requests SHALL grant the port not granted last (last-grant register updated on every grant); without it, port 0 SHALL always win ties and the last-grant register SHALL be absent.

Verification
REQ-026 req0 add 0xFFFF+0x2 alone -> req0_ready 1 cycle, rsp_valid 2 cycles after accept, rsp_result 0x10001, rsp_id 0, rsp_zeroFlag 0.
REQ-027 req1 mul 0xF*0x10, MULDIV_CYCLES=4 -> alu inputs stable 4 cycles, rsp_valid 5 cycles after accept, rsp_result 0xF0, rsp_id 1.
REQ-028 Both valid continuously with sub ops, ROUND_ROBIN_EN defined -> grants 0,1,0,1; undefined -> grants 0,0,0 while req0 held valid.
REQ-029 req0 opcode 1001 -> rsp_result 0, rsp_zeroFlag 1, rsp_error 1, 2 cycles after accept.
REQ-030 reset_n low during 2nd EXEC cycle of a div -> all outputs 0 immediately, no rsp_valid; after release, new add completes normally.
REQ-031 req0 sub 0x5-0x5 -> rsp_zeroFlag 1, rsp_result 0, rsp_error 0.
